// File: rtl/igr_combo_detect_if.sv
// igr_combo_detect_if
// Carries controller words from the sniffer to the IGR combo detector.
//   ctrl_data  [31:0] controller word (buttons in [15:0], stick X/Y above)
//   ctrl_valid        one-cycle strobe, ctrl_data valid in the same cycle
// Modports: master drives the word (sniffer side), slave consumes it.
interface igr_combo_detect_if;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;

  modport master (output ctrl_data, output ctrl_valid);
  modport slave  (input  ctrl_data, input  ctrl_valid);
endinterface

// File: rtl/igr_combo_detect.sv
// igr_combo_detect
// Turns polled controller words into in-game-routine actions. Each action is a
// one-cycle pulse fired after an exact button combo has been held for
// HOLD_POLLS consecutive polls. Also provides debounced button state, per-poll
// press edges and a controller-present flag with a poll timeout.
// Ports:
//   CLK_4M        sole clock
//   RST           synchronous active-high reset
//   ctrl          igr_combo_detect_if.slave (ctrl_data, ctrl_valid)
//   use_igr       enables action pulses while high
//   btn_state     masked buttons of the last poll
//   btn_press     one-cycle per-bit pulse of buttons newly pressed this poll
//   ctrl_present  a poll was seen within TIMEOUT_CYC cycles
//   igr_reset, tgl_deblur, tgl_15bit, osd_open   one-cycle action pulses
module igr_combo_detect #(
  parameter logic [15:0] RESET_COMBO  = 16'h080F,
  parameter logic [15:0] DEBLUR_COMBO = 16'h880C,
  parameter logic [15:0] BIT15_COMBO  = 16'h180C,
  parameter logic [15:0] OSD_COMBO    = 16'h0C80,
  parameter logic [3:0]  HOLD_POLLS   = 4'd8,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd40000
) (
  input  logic               CLK_4M,
  input  logic               RST,
  igr_combo_detect_if.slave  ctrl,
  input  logic               use_igr,
  output logic [15:0]        btn_state,
  output logic [15:0]        btn_press,
  output logic               ctrl_present,
  output logic               igr_reset,
  output logic               tgl_deblur,
  output logic               tgl_15bit,
  output logic               osd_open
);

  // A hold length of zero is treated as one poll.
  localparam logic [3:0] HOLD_EFF = (HOLD_POLLS == 4'd0) ? 4'd1 : HOLD_POLLS;

  // Bits 8 and 9 (joystick reset and the unused bit) never take part.
  localparam logic [15:0] BTN_MASK = 16'hFCFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_REL
  } state_t;

  state_t      state;
  logic [1:0]  cand;
  logic [3:0]  hold_cnt;
  logic [3:0]  act_pulse;
  logic [15:0] to_cnt;
  logic [15:0] btn;
  logic        poll;
  logic        to_expire;
  logic        match_hit;
  logic [1:0]  match_id;
  logic [4:0]  hold_next;
  logic        unused_ok;

  assign poll = ctrl.ctrl_valid;
  assign btn  = ctrl.ctrl_data[15:0] & BTN_MASK;

  // Stick axes are not used by the combo logic.
  assign unused_ok = &{1'b0, ctrl.ctrl_data[31:16]};

  // The timeout takes effect on the edge where the counter would reach
  // TIMEOUT_CYC; a poll in that same cycle wins.
  assign to_expire = !poll && (({1'b0, to_cnt} + 17'd1) == {1'b0, TIMEOUT_CYC});

  assign hold_next = {1'b0, hold_cnt} + 5'd1;

  // Exact combo match with fixed priority RESET > DEBLUR > BIT15 > OSD.
  always_comb begin
    match_hit = 1'b0;
    match_id  = 2'd0;
    if (btn == RESET_COMBO) begin
      match_hit = 1'b1;
      match_id  = 2'd0;
    end else if (btn == DEBLUR_COMBO) begin
      match_hit = 1'b1;
      match_id  = 2'd1;
    end else if (btn == BIT15_COMBO) begin
      match_hit = 1'b1;
      match_id  = 2'd2;
    end else if (btn == OSD_COMBO) begin
      match_hit = 1'b1;
      match_id  = 2'd3;
    end
  end

  function automatic logic [3:0] fire_vec(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Button state, press edges and controller-present tracking. A timeout
  // clears btn_state, so the next poll naturally compares against zero.
  always_ff @(posedge CLK_4M) begin
    if (RST) begin
      btn_state    <= '0;
      btn_press    <= '0;
      ctrl_present <= 1'b0;
      to_cnt       <= '0;
    end else begin
      btn_press <= '0;
      if (poll) begin
        btn_state    <= btn;
        btn_press    <= btn & ~btn_state;
        ctrl_present <= 1'b1;
        to_cnt       <= '0;
      end else if (to_cnt != TIMEOUT_CYC) begin
        to_cnt <= to_cnt + 16'd1;
        if (to_expire) begin
          ctrl_present <= 1'b0;
          btn_state    <= '0;
        end
      end
    end
  end

  // Combo hold FSM with registered action pulses. Disabling IGR or losing
  // the controller drops any hold in progress and suppresses pulses.
  always_ff @(posedge CLK_4M) begin
    if (RST) begin
      state     <= S_IDLE;
      cand      <= 2'd0;
      hold_cnt  <= '0;
      act_pulse <= '0;
    end else begin
      act_pulse <= '0;
      if (!use_igr || to_expire) begin
        state    <= S_IDLE;
        hold_cnt <= '0;
      end else if (poll) begin
        case (state)
          S_IDLE: begin
            if (match_hit) begin
              cand <= match_id;
              if (HOLD_EFF == 4'd1) begin
                act_pulse <= fire_vec(match_id);
                hold_cnt  <= '0;
                state     <= S_WAIT_REL;
              end else begin
                hold_cnt <= 4'd1;
                state    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (match_hit && (match_id == cand)) begin
              if (hold_next == {1'b0, HOLD_EFF}) begin
                act_pulse <= fire_vec(cand);
                hold_cnt  <= '0;
                state     <= S_WAIT_REL;
              end else begin
                hold_cnt <= hold_next[3:0];
              end
            end else if (match_hit) begin
              // Switching to another combo restarts the count for it.
              cand     <= match_id;
              hold_cnt <= 4'd1;
            end else begin
              hold_cnt <= '0;
              state    <= S_IDLE;
            end
          end
          S_WAIT_REL: begin
            // A full release is needed before any combo may fire again.
            if (btn == 16'h0000) begin
              state <= S_IDLE;
            end
          end
          default: begin
            hold_cnt <= '0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign igr_reset  = act_pulse[0];
  assign tgl_deblur = act_pulse[1];
  assign tgl_15bit  = act_pulse[2];
  assign osd_open   = act_pulse[3];

endmodule

// File: tb/tb_igr_combo_detect.sv
// tb_igr_combo_detect
// Self-checking bench for igr_combo_detect. A run-length reference model
// predicts every output each cycle; directed sequences pin the model with
// literal expectations, then a randomized phase exercises arbitrary polls,
// use_igr toggling and resets.
module tb_igr_combo_detect;

  localparam int HOLD = 8;
  localparam int TOUT = 40000;

  logic        clk;
  logic        rst;
  logic        use_igr;
  logic [15:0] btn_state;
  logic [15:0] btn_press;
  logic        ctrl_present;
  logic        igr_reset;
  logic        tgl_deblur;
  logic        tgl_15bit;
  logic        osd_open;

  igr_combo_detect_if ifc ();

  igr_combo_detect dut (
    .CLK_4M       (clk),
    .RST          (rst),
    .ctrl         (ifc),
    .use_igr      (use_igr),
    .btn_state    (btn_state),
    .btn_press    (btn_press),
    .ctrl_present (ctrl_present),
    .igr_reset    (igr_reset),
    .tgl_deblur   (tgl_deblur),
    .tgl_15bit    (tgl_15bit),
    .osd_open     (osd_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  int cnt_reset = 0;
  int cnt_deblur = 0;
  int cnt_15 = 0;
  int cnt_osd = 0;

  // Reference model state: the expected registered outputs after each edge.
  logic [15:0] m_btn = '0;
  logic [15:0] e_press = '0;
  bit          m_present = 0;
  logic [3:0]  e_pulse = '0;
  int          m_silent = 0;
  int          m_run = 0;
  int          m_id = 0;
  bit          m_latched = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int combo_id(input logic [15:0] b);
    if (b == 16'h080F) return 0;
    if (b == 16'h880C) return 1;
    if (b == 16'h180C) return 2;
    if (b == 16'h0C80) return 3;
    return -1;
  endfunction

  // Model: counts consecutive polls of the same combo; a pulse fires when
  // the run reaches HOLD, after which the combo is latched until all buttons
  // are released.
  always @(posedge clk) begin
    logic [15:0] b;
    bit          expire;
    int          id;
    b       = ifc.ctrl_data[15:0] & 16'hFCFF;
    e_press = '0;
    e_pulse = '0;
    expire  = 0;
    if (rst) begin
      m_btn = '0; m_present = 0; m_silent = 0;
      m_run = 0; m_id = 0; m_latched = 0;
    end else begin
      if (ifc.ctrl_valid) begin
        e_press   = b & ~m_btn;
        m_btn     = b;
        m_present = 1;
        m_silent  = 0;
      end else if (m_silent < TOUT) begin
        m_silent++;
        if (m_silent == TOUT) begin
          expire    = 1;
          m_present = 0;
          m_btn     = '0;
        end
      end
      if (!use_igr || expire) begin
        m_run = 0;
        m_latched = 0;
      end else if (ifc.ctrl_valid) begin
        if (m_latched) begin
          if (b == 16'h0000) m_latched = 0;
        end else begin
          id = combo_id(b);
          if (id < 0) m_run = 0;
          else if (m_run > 0 && id == m_id) m_run++;
          else begin
            m_id  = id;
            m_run = 1;
          end
          if (id >= 0 && m_run >= HOLD) begin
            e_pulse[id] = 1'b1;
            m_latched   = 1;
            m_run       = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("btn_state", {16'h0, btn_state}, {16'h0, m_btn});
      check_output("btn_press", {16'h0, btn_press}, {16'h0, e_press});
      check_output("ctrl_present", {31'h0, ctrl_present}, {31'h0, m_present});
      check_output("pulses", {28'h0, osd_open, tgl_15bit, tgl_deblur, igr_reset},
                   {28'h0, e_pulse});
    end
    if (!rst) begin
      cnt_reset  += int'(igr_reset);
      cnt_deblur += int'(tgl_deblur);
      cnt_15     += int'(tgl_15bit);
      cnt_osd    += int'(osd_open);
    end
  end

  // One poll: strobe for one cycle, then one idle cycle. Returns just after
  // the edge that sampled the strobe, so registered outputs reflect it.
  task automatic apply_stimulus(input logic [31:0] data);
    @(posedge clk); #1;
    ifc.ctrl_data  = data;
    ifc.ctrl_valid = 1'b1;
    @(posedge clk); #1;
    ifc.ctrl_valid = 1'b0;
  endtask

  task automatic apply_n(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(data);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  function automatic logic [15:0] pick_btn();
    logic [15:0] combos [4];
    logic [31:0] r;
    combos[0] = 16'h080F; combos[1] = 16'h880C;
    combos[2] = 16'h180C; combos[3] = 16'h0C80;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1, 2, 3, 4: return combos[$urandom_range(0, 3)];
      5:       return combos[$urandom_range(0, 3)] | (16'h0001 << $urandom_range(0, 15));
      6:       return combos[$urandom_range(0, 3)] | 16'h0300;
      default: return r[15:0];
    endcase
  endfunction

  initial begin
    logic [15:0] cur;
    logic [31:0] r;
    rst            = 1'b1;
    use_igr        = 1'b1;
    ifc.ctrl_data  = '0;
    ifc.ctrl_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1;
    check_output("reset_btn_state", {16'h0, btn_state}, 32'h0);
    check_output("reset_btn_press", {16'h0, btn_press}, 32'h0);
    check_output("reset_present", {31'h0, ctrl_present}, 32'h0);
    check_output("reset_pulses", {28'h0, osd_open, tgl_15bit, tgl_deblur, igr_reset}, 32'h0);
    rst = 1'b0;

    // Hold length: 7 polls do nothing, 8 polls fire once.
    apply_n(32'h0000080F, 7);
    settle();
    check_output("hold7_no_pulse", cnt_reset, 0);
    apply_stimulus(32'h0);
    apply_n(32'h0000080F, 7);
    apply_stimulus(32'h0000080F);
    check_output("hold8_pulse", {31'h0, igr_reset}, 32'h1);
    settle();
    check_output("hold8_count", cnt_reset, 1);

    // Release rule.
    apply_stimulus(32'h0);
    apply_n(32'h0000080F, 20);
    settle();
    check_output("hold20_single", cnt_reset, 2);
    apply_stimulus(32'h0);
    apply_n(32'h0000080F, 8);
    settle();
    check_output("refire_after_release", cnt_reset, 3);

    // Combo switch and mid-hold break.
    apply_stimulus(32'h0);
    apply_n(32'h0000880C, 4);
    apply_n(32'h0000180C, 8);
    settle();
    check_output("switch_15bit", cnt_15, 1);
    check_output("switch_no_deblur", cnt_deblur, 0);
    apply_stimulus(32'h0);
    apply_n(32'h0000080F, 4);
    apply_stimulus(32'h0000080D);
    apply_n(32'h0000080F, 7);
    settle();
    check_output("break_restarts", cnt_reset, 3);
    apply_stimulus(32'h0000080F);
    settle();
    check_output("break_then_fire", cnt_reset, 4);

    // Masking and press edges.
    apply_stimulus(32'h0);
    apply_stimulus(32'hABCD0300);
    check_output("mask_state", {16'h0, btn_state}, 32'h0);
    apply_stimulus(32'h55AA0001);
    check_output("press_new", {16'h0, btn_press}, 32'h1);
    @(posedge clk); #1;
    check_output("press_one_cycle", {16'h0, btn_press}, 32'h0);
    apply_stimulus(32'h00000001);
    check_output("press_repeat", {16'h0, btn_press}, 32'h0);
    apply_stimulus(32'h00000011);
    check_output("press_add", {16'h0, btn_press}, 32'h10);

    // Gating with use_igr.
    apply_stimulus(32'h0);
    use_igr = 1'b0;
    apply_n(32'h0000080F, 10);
    settle();
    check_output("gated_no_pulse", cnt_reset, 4);
    use_igr = 1'b1;
    apply_n(32'h0000080F, 7);
    settle();
    check_output("gate_restart_7", cnt_reset, 4);
    apply_stimulus(32'h0000080F);
    check_output("gate_restart_8", {31'h0, igr_reset}, 32'h1);

    // Timeout: a poll at the last possible cycle keeps the controller present.
    apply_stimulus(32'h0);
    apply_stimulus(32'h00000C80);
    repeat (TOUT - 2) @(posedge clk);
    apply_stimulus(32'h00000C80);
    check_output("poll_beats_timeout", {31'h0, ctrl_present}, 32'h1);
    repeat (TOUT) @(posedge clk);
    #1;
    check_output("timeout_present", {31'h0, ctrl_present}, 32'h0);
    check_output("timeout_state", {16'h0, btn_state}, 32'h0);
    apply_stimulus(32'h00000C80);
    check_output("press_after_timeout", {16'h0, btn_press}, 32'h0C80);
    apply_n(32'h00000C80, 6);
    settle();
    check_output("timeout_idle_7", cnt_osd, 0);
    apply_stimulus(32'h00000C80);
    check_output("timeout_idle_8", {31'h0, osd_open}, 32'h1);

    // Randomized phase against the model.
    cur = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 15) == 0) cur = pick_btn();
      r = $urandom();
      ifc.ctrl_data  = {r[31:16], cur};
      ifc.ctrl_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 63) == 0) use_igr = ~use_igr;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    rst            = 1'b0;
    ifc.ctrl_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
